cp0_hilo: RTL and testbench
===========================

# cp0_hilo

Coprocessor-0 and HI/LO register unit on the CPU's coprocessor side, answering `mtc0`/`mfc0`/`mthi`/`mfhi`/`mtlo`/`mflo`/`c0_eret` from the pipeline. Holds Status, Cause, EPC, Count and Compare, plus HI and LO. Detects address-error and interrupt exceptions, redirects the PC mux, and runs a short flush sequence. Read data returns to the pipeline on `rdfcp0`.

## Interface
- `EXC_VECTOR`, 32'h0000_0004, exception handler address.
- `FLUSH_CYCLES`, 2, cycles `exc_flush` stays high after an exception is taken (≥1).
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mtc0`, `mfc0`, `mthi`, `mfhi`, `mtlo`, `mflo`, `c0_eret` in 1 each: decoded controls from ID.
- `reg_d` in 5: CP0 register number.
- `rt2cp0` in 32: write data for `mtc0`.
- `rs2hilo` in 32: write data for `mthi`/`mtlo`.
- `add_err` in 1: address error from MEM.
- `cur_pc` in 32: PC of the instruction that raised the event.
- `int_in` in 5: external interrupt lines, level-sensitive.
- `rdfcp0` out 32: read data.
- `epc` out 32: current EPC.
- `exc_taken` out 1: PC mux selects `EXVECTOR`.
- `eret_taken` out 1: PC mux selects `epc`.
- `exc_flush` out 1: squashes the IF/ID/EXE stages.

## Operation
- Registers:
  - Status (12): bit0 IE, bit1 EXL, [14:10] IM. Other bits read 0.
  - Cause (13): [14:10] IP, which mirrors `int_in` each cycle; [15] timer pending TI; [6:2] ExcCode. Other bits read 0.
  - EPC (14), Count (9), Compare (11).
  - Unimplemented numbers read 0; writes to them are ignored.
  - IM[15] is Status bit 15 and enables TI.
- Reads (combinational), priority `mfc0` > `mfhi` > `mflo`; otherwise `rdfcp0` = 0. There is no write-to-read bypass: a same-cycle read returns the old value.
- Writes happen at the clock edge: `mtc0` to reg_d, `mthi` to HI, `mtlo` to LO. `mthi` and `mtlo` in the same cycle both complete.
- Count increments by 1 every cycle and wraps at 2^32. An `mtc0` to Count loads the written value in place of the increment.
- When Count == Compare, TI is set (sticky). An `mtc0` to Compare clears TI. If a match and a Compare write fall in the same cycle, the clear wins.
- Interrupt request: IE & !EXL & |({TI,IP} & {IM15,IM}).
- Exception priority, evaluated only in state RUN:
  - `add_err` (ExcCode 5'd4) is highest.
  - Interrupt (ExcCode 5'd0) is next.
- Taking an exception:
  - EPC ← `cur_pc`, EXL ← 1, ExcCode set.
  - `exc_taken` = 1 and `exc_flush` = 1 for that cycle.
  - Next state is FLUSH.
  - In the same cycle, field updates from the exception override `mtc0` to Status/Cause/EPC, and `c0_eret` is ignored.
- ERET in RUN with no exception pending: EXL ← 0, `eret_taken` = 1.
- FSM states:
  - RUN: exceptions and ERET are accepted.
  - FLUSH: a counter loads `FLUSH_CYCLES`−1 when FLUSH is entered. `exc_flush` = 1 for the whole of FLUSH.
  - While in FLUSH, all `mt*` writes and `c0_eret` are ignored, and new exceptions are not sampled.
  - When the counter reaches 0, the FSM returns to RUN.

## Timing
- Reset (rst low, asynchronous):
  - All registers = 0; state = RUN.
  - `exc_taken`, `eret_taken`, `exc_flush` = 0.
  - `rdfcp0` = 0 and `epc` = 0.
- Reset asserted mid-FLUSH aborts the flush immediately.
- `exc_taken` and `eret_taken` are combinational single-cycle pulses, valid in the detection cycle.
- State updates land at the following edge.
- Total `exc_flush` high time per exception is exactly `FLUSH_CYCLES` cycles: the detection cycle plus `FLUSH_CYCLES`−1 cycles in FLUSH.
- EXL=1 after the edge blocks re-entry of interrupts until ERET.
- `add_err` is not masked by EXL.
- Write-to-read latency is 1 cycle.

## Structure
- Shared package/include (`globaldefine.v`) holds:
  - CP0 register numbers 9/11/12/13/14.
  - ExcCodes 4 and 0.
  - Status/Cause bit positions.
  - State encodings RUN and FLUSH.
- One sub-module, `cp0_timer`, holds Count, Compare and TI. Its ports: write enables, write data, TI clear, Count, Compare, TI.
- Everything else lives in `cp0_hilo`.

## Test plan
- `mthi` 32'hDEAD_BEEF, `mtlo` 32'h1234_5678 in the same cycle; next cycle `mfhi` → `rdfcp0` = DEADBEEF; then `mflo` → `rdfcp0` = 12345678.
- `mtc0` Status = 32'h0000_0401 (IE, IM10); raise `int_in[0]` with `cur_pc` = 32'h40 →
  - `exc_taken` pulse; EPC = 0x40; ExcCode = 0; EXL = 1.
  - `exc_flush` high exactly 2 cycles.
  - Holding `int_in` does not retrigger.
- During the above FLUSH, `mtc0` EPC = 0x99 and `c0_eret` are both ignored. Then `c0_eret` in RUN → `eret_taken` = 1, `epc` = 0x40, EXL = 0.
- `add_err` and an enabled interrupt in the same cycle as `mtc0` EPC = 0x77 → ExcCode = 4, EPC = `cur_pc`.
- Count = 0xFFFF_FFFE written, Compare = 0 → after 2 cycles Count = 0 and TI = 1. `mtc0` Compare in a match cycle → TI = 0.
- Assert `rst` low during FLUSH → all outputs 0 immediately, state = RUN, HI = LO = 0.

Source files
------------

// File: rtl/cp0_hilo_pkg.sv
// cp0_hilo_pkg: shared definitions for the CP0 / HI-LO unit.
//   - CP0 register numbers (Count, Compare, Status, Cause, EPC)
//   - exception codes (address error, interrupt) and handler address
//   - Status / Cause bit positions
//   - FSM state encoding (RUN, FLUSH)
//   - helpers that assemble the architectural Status / Cause read words
package cp0_hilo_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0004;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_ADE = 5'd4;
  localparam logic [4:0] EXC_INT = 5'd0;

  // Status fields
  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 10;
  localparam int ST_IM_HI = 15;   // IM[15] gates the timer interrupt

  // Cause fields
  localparam int CA_EXC_LO = 2;
  localparam int CA_EXC_HI = 6;
  localparam int CA_IP_LO  = 10;
  localparam int CA_IP_HI  = 14;
  localparam int CA_TI     = 15;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Status read word: only IE, EXL and IM[15:10] exist, everything else is 0.
  function automatic logic [31:0] status_word(input logic ie, input logic exl,
                                              input logic [5:0] im);
    logic [31:0] w;
    w = '0;
    w[ST_IE] = ie;
    w[ST_EXL] = exl;
    w[ST_IM_HI:ST_IM_LO] = im;
    return w;
  endfunction

  // Cause read word: TI, IP (live interrupt lines) and ExcCode.
  function automatic logic [31:0] cause_word(input logic ti, input logic [4:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] w;
    w = '0;
    w[CA_TI] = ti;
    w[CA_IP_HI:CA_IP_LO] = ip;
    w[CA_EXC_HI:CA_EXC_LO] = exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_hilo_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-pending bit TI.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   count_we        load Count with wdata instead of incrementing
//   compare_we      load Compare with wdata
//   wdata           write data shared by both registers
//   ti_clr          clear TI (wins over a same-cycle match)
//   count, compare  current register values
//   ti              timer interrupt pending
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  input  logic        ti_clr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        ti_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      // A Count write replaces this cycle's increment; the add wraps naturally.
      count_reg <= count_we ? wdata : count_reg + 32'd1;
      if (compare_we) begin
        compare_reg <= wdata;
      end
      if (ti_clr) begin
        ti_reg <= 1'b0;
      end else if (count_reg == compare_reg) begin
        ti_reg <= 1'b1;
      end
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti      = ti_reg;

endmodule

// File: rtl/cp0_hilo.sv
// cp0_hilo: coprocessor-0 registers (Status, Cause, EPC, Count, Compare) and
// the HI/LO pair. Detects address-error and interrupt exceptions, drives the
// PC-mux selects and holds the front-end flushed for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   mtc0/mfc0/mthi/mfhi/mtlo/mflo/c0_eret   decoded controls from ID
//   reg_d                       CP0 register number
//   rt2cp0                      mtc0 write data
//   rs2hilo                     mthi/mtlo write data
//   add_err                     address error from MEM
//   cur_pc                      PC of the instruction raising the event
//   int_in                      level-sensitive external interrupts
//   rdfcp0                      read data (combinational)
//   epc                         current EPC
//   exc_taken / eret_taken      PC mux selects the exception vector / EPC
//   exc_flush                   squash IF/ID/EXE
module cp0_hilo
  import cp0_hilo_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic        mthi,
  input  logic        mfhi,
  input  logic        mtlo,
  input  logic        mflo,
  input  logic        c0_eret,
  input  logic [4:0]  reg_d,
  input  logic [31:0] rt2cp0,
  input  logic [31:0] rs2hilo,
  input  logic        add_err,
  input  logic [31:0] cur_pc,
  input  logic [4:0]  int_in,
  output logic [31:0] rdfcp0,
  output logic [31:0] epc,
  output logic        exc_taken,
  output logic        eret_taken,
  output logic        exc_flush
);

  // The counter holds the number of FLUSH cycles still to run, so it needs
  // to represent FLUSH_CYCLES-1.
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic        ie_reg;
  logic        exl_reg;
  logic [5:0]  im_reg;       // IM[15:10]
  logic [4:0]  exc_code_reg;
  logic [31:0] epc_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic        in_run;
  logic        irq;
  logic        exc_addr;
  logic        exc_int;
  logic        exc;
  logic        eret;
  logic        c0_we;
  logic        count_we;
  logic        compare_we;
  logic [31:0] cp0_rd;
  logic [31:0] rd_mux;

  assign in_run = (state_reg == ST_RUN);

  // {TI, IP[14:10]} lines up bit-for-bit with IM[15:10].
  assign irq = ie_reg & ~exl_reg & (|({ti, int_in} & im_reg));

  // Address error is not masked by EXL; it outranks a pending interrupt.
  assign exc_addr = in_run & add_err;
  assign exc_int  = in_run & ~add_err & irq;
  assign exc      = exc_addr | exc_int;
  assign eret     = in_run & c0_eret & ~exc;

  // All register writes are frozen while the pipeline is being flushed.
  assign c0_we      = in_run & mtc0;
  assign count_we   = c0_we & (reg_d == CP0_COUNT);
  assign compare_we = c0_we & (reg_d == CP0_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (count_we),
    .compare_we (compare_we),
    .wdata      (rt2cp0),
    .ti_clr     (compare_we),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Read path: no bypass, a same-cycle write is seen one cycle later.
  always_comb begin
    cp0_rd = '0;
    case (reg_d)
      CP0_COUNT:   cp0_rd = count;
      CP0_COMPARE: cp0_rd = compare;
      CP0_STATUS:  cp0_rd = status_word(ie_reg, exl_reg, im_reg);
      CP0_CAUSE:   cp0_rd = cause_word(ti, int_in, exc_code_reg);
      CP0_EPC:     cp0_rd = epc_reg;
      default:     cp0_rd = '0;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    if (mfc0) begin
      rd_mux = cp0_rd;
    end else if (mfhi) begin
      rd_mux = hi_reg;
    end else if (mflo) begin
      rd_mux = lo_reg;
    end
  end

  // Combinational outputs are forced low while reset is held so that the
  // PC mux and flush are quiet immediately, not just after the next edge.
  assign rdfcp0     = rst ? rd_mux : '0;
  assign exc_taken  = rst & exc;
  assign eret_taken = rst & eret;
  assign exc_flush  = rst & (exc | (state_reg == ST_FLUSH));
  assign epc        = epc_reg;

  // Status / Cause / EPC. Later assignments in this block take precedence,
  // so exception updates override mtc0 and ERET overrides a Status write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_reg       <= 1'b0;
      exl_reg      <= 1'b0;
      im_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      if (c0_we && (reg_d == CP0_STATUS)) begin
        ie_reg  <= rt2cp0[ST_IE];
        exl_reg <= rt2cp0[ST_EXL];
        im_reg  <= rt2cp0[ST_IM_HI:ST_IM_LO];
      end
      if (c0_we && (reg_d == CP0_CAUSE)) begin
        exc_code_reg <= rt2cp0[CA_EXC_HI:CA_EXC_LO];
      end
      if (c0_we && (reg_d == CP0_EPC)) begin
        epc_reg <= rt2cp0;
      end
      if (eret) begin
        exl_reg <= 1'b0;
      end
      if (exc) begin
        epc_reg      <= cur_pc;
        exl_reg      <= 1'b1;
        exc_code_reg <= exc_addr ? EXC_ADE : EXC_INT;
      end
    end
  end

  // HI / LO: both may be written in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (in_run && mthi) begin
        hi_reg <= rs2hilo;
      end
      if (in_run && mtlo) begin
        lo_reg <= rs2hilo;
      end
    end
  end

  // Flush sequencer. The detection cycle already flushes, so FLUSH itself
  // lasts FLUSH_CYCLES-1 cycles; with FLUSH_CYCLES == 1 it is skipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (exc && (FLUSH_CYCLES > 1)) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_reg <= CNT_ONE) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= '0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - CNT_ONE;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          flush_cnt_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_hilo.sv
module tb_cp0_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        mtc0, mfc0, mthi, mfhi, mtlo, mflo, c0_eret;
  logic [4:0]  reg_d;
  logic [31:0] rt2cp0, rs2hilo;
  logic        add_err;
  logic [31:0] cur_pc;
  logic [4:0]  int_in;
  logic [31:0] rdfcp0, epc;
  logic        exc_taken, eret_taken, exc_flush;

  always #5 clk = ~clk;

  cp0_hilo #(.FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mtc0       (mtc0),
    .mfc0       (mfc0),
    .mthi       (mthi),
    .mfhi       (mfhi),
    .mtlo       (mtlo),
    .mflo       (mflo),
    .c0_eret    (c0_eret),
    .reg_d      (reg_d),
    .rt2cp0     (rt2cp0),
    .rs2hilo    (rs2hilo),
    .add_err    (add_err),
    .cur_pc     (cur_pc),
    .int_in     (int_in),
    .rdfcp0     (rdfcp0),
    .epc        (epc),
    .exc_taken  (exc_taken),
    .eret_taken (eret_taken),
    .exc_flush  (exc_flush)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;

  // Independent model of the architectural read words.
  function automatic logic [31:0] m_status(input logic ie, input logic exl, input logic [5:0] im);
    return {16'h0, im, 8'h0, exl, ie};
  endfunction

  function automatic logic [31:0] m_cause(input logic ti, input logic [4:0] ip, input logic [4:0] code);
    return {16'h0, ti, ip, 3'b000, code, 2'b00};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty observed=%h required=<none>", obs);
    end else begin
      e = sb.pop_front();
      $display("check %-16s observed=%h expected=%h", e.tag, obs, e.val);
      assert (obs === e.val) passed++;
      else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_ctl();
    mtc0 = 0; mfc0 = 0; mthi = 0; mfhi = 0; mtlo = 0; mflo = 0; c0_eret = 0;
    reg_d = '0; rt2cp0 = '0; rs2hilo = '0; add_err = 0; cur_pc = '0;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled on the
  // falling edge; the step closes at the next rising edge.
  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic end_step();
    @(posedge clk);
    #1;
    clear_ctl();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ctl();
    int_in = '0;
    rst = 1'b0;
    // Live controls during reset must not leak to the outputs.
    add_err = 1; c0_eret = 1; mfhi = 1;
    #3;
    push("rst_rdfcp0", 32'h0);     push("rst_epc", 32'h0);
    push("rst_exc_taken", 32'h0);  push("rst_eret_taken", 32'h0);
    push("rst_exc_flush", 32'h0);
    pop_check(rdfcp0); pop_check(epc); pop_check({31'h0, exc_taken});
    pop_check({31'h0, eret_taken}); pop_check({31'h0, exc_flush});
    @(negedge clk);
    clear_ctl();
    rst = 1'b1;
    @(posedge clk); #1;
    // Count == Compare == 0 on the first edge after reset: TI is now 1.

    // HI/LO
    mthi = 1; mtlo = 1; rs2hilo = 32'hDEAD_BEEF; mfhi = 1;
    push("hi_no_bypass", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mflo = 1; mtlo = 1; rs2hilo = 32'h1234_5678;
    push("lo_both_write", 32'hDEAD_BEEF);
    to_sample(); pop_check(rdfcp0); end_step();

    mfhi = 1;
    push("mfhi", 32'hDEAD_BEEF);
    to_sample(); pop_check(rdfcp0); end_step();

    mflo = 1;
    push("mflo", 32'h1234_5678);
    to_sample(); pop_check(rdfcp0); end_step();

    mfhi = 1; mflo = 1;
    push("hi_over_lo", 32'hDEAD_BEEF);
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd12; mfhi = 1;
    push("c0_over_hi", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    // Status = IE | IM10
    mtc0 = 1; reg_d = 5'd12; rt2cp0 = 32'h0000_0401;
    push("wr_status_noexc", 32'h0);
    to_sample(); pop_check({31'h0, exc_taken}); end_step();

    mfc0 = 1; reg_d = 5'd12;
    push("rd_status", m_status(1'b1, 1'b0, 6'b000001));
    to_sample(); pop_check(rdfcp0); end_step();

    // Interrupt with a simultaneous ERET (ignored)
    int_in = 5'b00001; cur_pc = 32'h40; c0_eret = 1;
    push("int_exc_taken", 32'h1); push("int_flush0", 32'h1); push("int_eret_ign", 32'h0);
    to_sample(); pop_check({31'h0, exc_taken}); pop_check({31'h0, exc_flush});
    pop_check({31'h0, eret_taken}); end_step();

    // FLUSH: mtc0 EPC and ERET ignored
    mtc0 = 1; reg_d = 5'd14; rt2cp0 = 32'h99; c0_eret = 1; cur_pc = 32'h80;
    push("fl_exc_taken", 32'h0); push("fl_flush1", 32'h1); push("fl_eret_ign", 32'h0);
    to_sample(); pop_check({31'h0, exc_taken}); pop_check({31'h0, exc_flush});
    pop_check({31'h0, eret_taken}); end_step();

    // Back in RUN with int_in still high: EXL blocks re-entry
    mfc0 = 1; reg_d = 5'd14;
    push("flush_ended", 32'h0); push("no_retrigger", 32'h0); push("epc_after_int", 32'h40);
    to_sample(); pop_check({31'h0, exc_flush}); pop_check({31'h0, exc_taken});
    pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd12;
    push("status_exl", m_status(1'b1, 1'b1, 6'b000001)); push("no_retrigger2", 32'h0);
    to_sample(); pop_check(rdfcp0); pop_check({31'h0, exc_taken}); end_step();

    mfc0 = 1; reg_d = 5'd13;
    push("cause_int", m_cause(1'b1, 5'b00001, 5'd0));
    to_sample(); pop_check(rdfcp0); end_step();

    // ERET in RUN
    int_in = '0; c0_eret = 1;
    push("eret_taken", 32'h1); push("eret_epc", 32'h40); push("eret_noexc", 32'h0);
    to_sample(); pop_check({31'h0, eret_taken}); pop_check(epc);
    pop_check({31'h0, exc_taken}); end_step();

    mfc0 = 1; reg_d = 5'd12;
    push("status_exl0", m_status(1'b1, 1'b0, 6'b000001));
    to_sample(); pop_check(rdfcp0); end_step();

    // Address error + interrupt + mtc0 EPC in the same cycle
    int_in = 5'b00001; add_err = 1; cur_pc = 32'h200;
    mtc0 = 1; reg_d = 5'd14; rt2cp0 = 32'h77;
    push("ade_exc_taken", 32'h1);
    to_sample(); pop_check({31'h0, exc_taken}); end_step();

    int_in = '0;
    push("ade_flush1", 32'h1);
    to_sample(); pop_check({31'h0, exc_flush}); end_step();

    mfc0 = 1; reg_d = 5'd13;
    push("cause_ade", m_cause(1'b1, 5'b0, 5'd4)); push("ade_flush_end", 32'h0);
    to_sample(); pop_check(rdfcp0); pop_check({31'h0, exc_flush}); end_step();

    mfc0 = 1; reg_d = 5'd14;
    push("epc_ade_rd", 32'h200); push("epc_ade_out", 32'h200);
    to_sample(); pop_check(rdfcp0); pop_check(epc); end_step();

    c0_eret = 1;
    push("eret2", 32'h1);
    to_sample(); pop_check({31'h0, eret_taken}); end_step();

    // Timer: Compare write clears TI
    mtc0 = 1; reg_d = 5'd11; rt2cp0 = 32'h0;
    push("cmp_wr_rd0", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd13;
    push("ti_cleared", m_cause(1'b0, 5'b0, 5'd4));
    to_sample(); pop_check(rdfcp0); end_step();

    mtc0 = 1; reg_d = 5'd9; rt2cp0 = 32'hFFFF_FFFE;
    push("cnt_wr_idle", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    for (int i = 0; i < 3; i++) begin
      logic [31:0] cexp;
      cexp = 32'hFFFF_FFFE + 32'(i);
      mfc0 = 1; reg_d = 5'd9;
      push($sformatf("count_%0d", i), cexp);
      to_sample(); pop_check(rdfcp0); end_step();
    end

    mfc0 = 1; reg_d = 5'd13;
    push("ti_set", m_cause(1'b1, 5'b0, 5'd4));
    to_sample(); pop_check(rdfcp0); end_step();

    // Compare write in a match cycle: clear wins
    mtc0 = 1; reg_d = 5'd11; rt2cp0 = 32'h0;
    push("cmp_clr_idle", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mtc0 = 1; reg_d = 5'd9; rt2cp0 = 32'hFFFF_FFFE;
    push("cnt_wr2_idle", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    for (int i = 0; i < 2; i++) begin
      push($sformatf("wait_ti0_%0d", i), m_cause(1'b0, 5'b0, 5'd4));
      mfc0 = 1; reg_d = 5'd13;
      to_sample(); pop_check(rdfcp0); end_step();
    end

    mtc0 = 1; reg_d = 5'd11; rt2cp0 = 32'h100; mfc0 = 1;
    push("match_cycle_cnt", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd13;
    push("clear_wins", m_cause(1'b0, 5'b0, 5'd4));
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd11;
    push("rd_compare", 32'h100);
    to_sample(); pop_check(rdfcp0); end_step();

    // Unimplemented register
    mtc0 = 1; reg_d = 5'd5; rt2cp0 = 32'hFFFF_FFFF;
    push("unimpl_wr_idle", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd5;
    push("unimpl_rd", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    // Reset asserted mid-FLUSH
    int_in = 5'b00001; cur_pc = 32'h300;
    push("pre_rst_exc", 32'h1);
    to_sample(); pop_check({31'h0, exc_taken}); end_step();

    int_in = '0; mfhi = 1;
    push("pre_rst_flush", 32'h1); push("pre_rst_hi", 32'hDEAD_BEEF);
    to_sample(); pop_check({31'h0, exc_flush}); pop_check(rdfcp0);
    #2;
    rst = 1'b0;
    #1;
    push("rst_fl_flush", 32'h0); push("rst_fl_rd", 32'h0);
    push("rst_fl_epc", 32'h0);   push("rst_fl_exc", 32'h0);
    pop_check({31'h0, exc_flush}); pop_check(rdfcp0);
    pop_check(epc); pop_check({31'h0, exc_taken});
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    clear_ctl();

    mfhi = 1;
    push("post_rst_hi", 32'h0); push("post_rst_run", 32'h0);
    to_sample(); pop_check(rdfcp0); pop_check({31'h0, exc_flush}); end_step();

    mflo = 1;
    push("post_rst_lo", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    mfc0 = 1; reg_d = 5'd12;
    push("post_rst_status", 32'h0);
    to_sample(); pop_check(rdfcp0); end_step();

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
